// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and helpers shared by the IF-stage fetch address logic.
//   RESET_VEC / EXC_VEC : default reset and exception entry vectors
//   redir_e / redir_sel : redirect source encoding and its priority order
//   clog2               : elaboration-time width helper
package fetch_pkg;

    localparam logic [31:0] RESET_VEC = 32'hbfc0_0000;
    localparam logic [31:0] EXC_VEC   = 32'hbfc0_0380;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_ERET = 2'd1,
        REDIR_EXC  = 2'd2,
        REDIR_BR   = 2'd3
    } redir_e;

    // eret beats exception, exception beats branch
    function automatic redir_e redir_sel(input logic eret, input logic exc, input logic br);
        if (eret)     return REDIR_ERET;
        else if (exc) return REDIR_EXC;
        else if (br)  return REDIR_BR;
        else          return REDIR_NONE;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: instruction-memory request/response bundle.
//   req_valid/req_ready : fetch request handshake
//   req_addr/req_mask   : group-aligned address and per-slot valid mask
//   resp_valid          : one in-order response returned
//   resp_discard        : response belongs to a stale request
// master = fetch address generator, slave = instruction memory side.
interface fetch_pc_gen_if #(
    parameter int unsigned FETCH_W = 1
) ();

    logic               req_valid;
    logic               req_ready;
    logic [31:0]        req_addr;
    logic [FETCH_W-1:0] req_mask;
    logic               resp_valid;
    logic               resp_discard;

    modport master (
        output req_valid, req_addr, req_mask, resp_discard,
        input  req_ready, resp_valid
    );

    modport slave (
        input  req_valid, req_addr, req_mask, resp_discard,
        output req_ready, resp_valid
    );

endinterface

// File: rtl/fetch_inflight_ctr.sv
// fetch_inflight_ctr: outstanding-request and stale-request counters.
//   clk, rst     : clock, async active-high reset
//   fire         : a request is accepted this cycle
//   resp_valid   : a response returns this cycle (in order)
//   redir        : redirect; everything in flight (plus a firing request) goes stale
//   stale_inc    : one more request (the firing one) is stale
//   outst        : accepted requests not yet answered
//   resp_discard : current response is stale
module fetch_inflight_ctr #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire,
    input  logic             resp_valid,
    input  logic             redir,
    input  logic             stale_inc,
    output logic [CNT_W-1:0] outst,
    output logic             resp_discard
);

    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] stale_q, stale_d;
    logic             stale_nz;

    assign stale_nz = (stale_q != '0);

    always_comb begin
        outst_d = outst_q + CNT_W'(fire) - CNT_W'(resp_valid);
        if (redir)
            stale_d = outst_q + CNT_W'(fire) - CNT_W'(resp_valid);
        else
            stale_d = stale_q - CNT_W'(resp_valid & stale_nz) + CNT_W'(stale_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_q <= '0;
            stale_q <= '0;
        end else begin
            outst_q <= outst_d;
            stale_q <= stale_d;
        end
    end

    assign outst        = outst_q;
    assign resp_discard = resp_valid & stale_nz;

    a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
        !(resp_valid && outst_q == '0));

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: IF-stage fetch address generator.
//   clk, reset       : clock, async active-high reset
//   stall            : IF cannot accept new fetches
//   eret/epc         : redirect to epc
//   exc_oc           : redirect to EXC_ADDR
//   br_take/br_target: redirect to branch target
//   mem (master)     : request handshake, aligned address, slot mask, response discard
//   pc               : current fetch PC
//   outst            : accepted-but-unanswered requests
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_VEC,
    parameter logic [31:0] EXC_ADDR   = EXC_VEC,
    parameter int unsigned FETCH_W    = 1,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        exc_oc,
    input  logic        br_take,
    input  logic [31:0] br_target,
    fetch_pc_gen_if.master mem,
    output logic [31:0] pc,
    output logic [2:0]  outst
);

    localparam int unsigned GB      = 4 * FETCH_W;
    localparam int unsigned OFF_W   = clog2(GB);
    localparam logic [31:0] GB_MASK = ~(32'(GB) - 32'd1);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        hold_q, hold_d;
    logic        pend_q, pend_d;
    logic        redir_now;
    logic [31:0] target;
    logic        req_valid;
    logic        fire;
    logic        stale_inc;
    logic [31:0] seq_pc;

    assign redir_now = eret | exc_oc | br_take;

    always_comb begin
        case (redir_sel(eret, exc_oc, br_take))
            REDIR_ERET: target = epc;
            REDIR_EXC:  target = EXC_ADDR;
            default:    target = br_target;
        endcase
    end

    // A held request stays valid whatever stall/redirect do; reset forces it low.
    assign req_valid = ~reset & (hold_q |
                       (~stall & (outst < 3'(MAX_OUTST)) & ~redir_now & ~pend_q));
    assign fire      = req_valid & mem.req_ready;
    assign seq_pc    = (pc_q & GB_MASK) + 32'(GB);

    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        stale_inc   = 1'b0;
        hold_d      = req_valid & ~mem.req_ready;
        if (redir_now) begin
            if (hold_q && !fire) begin
                // pc must stay on the held request; park the newest target
                pend_d      = 1'b1;
                pend_addr_d = target;
            end else begin
                pc_d   = target;
                pend_d = 1'b0;
            end
        end else if (fire) begin
            if (pend_q) begin
                // held request was already wrong-path when it fired
                pc_d      = pend_addr_q;
                pend_d    = 1'b0;
                stale_inc = 1'b1;
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_ADDR;
            pend_addr_q <= '0;
            hold_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
        end
    end

    generate
        if (FETCH_W == 1) begin : g_mask1
            assign mem.req_mask = '1;
        end else begin : g_maskn
            logic [OFF_W-3:0] slot;
            assign slot = pc_q[OFF_W-1:2];
            always_comb begin
                for (int unsigned i = 0; i < FETCH_W; i++)
                    mem.req_mask[i] = (i >= 32'(slot));
            end
        end
    endgenerate

    fetch_inflight_ctr #(
        .CNT_W(3)
    ) u_ctr (
        .clk          (clk),
        .rst          (reset),
        .fire         (fire),
        .resp_valid   (mem.resp_valid),
        .redir        (redir_now),
        .stale_inc    (stale_inc),
        .outst        (outst),
        .resp_discard (mem.resp_discard)
    );

    assign mem.req_valid = req_valid;
    assign mem.req_addr  = pc_q & GB_MASK;
    assign pc            = pc_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vectors for fetch_pc_gen. A FETCH_W=1 and a FETCH_W=4
// instance share all stimulus; the 4-wide one is checked on its aligned address/mask.
module tb_fetch_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        eret;
    logic [31:0] epc;
    logic        exc_oc;
    logic        br_take;
    logic [31:0] br_target;
    logic        ready;
    logic        resp;
    logic [31:0] pc1, pc4;
    logic [2:0]  outst1, outst4;

    int unsigned n_vec;
    int unsigned n_err;

    fetch_pc_gen_if #(.FETCH_W(1)) if1 ();
    fetch_pc_gen_if #(.FETCH_W(4)) if4 ();

    assign if1.req_ready  = ready;
    assign if1.resp_valid = resp;
    assign if4.req_ready  = ready;
    assign if4.resp_valid = resp;

    fetch_pc_gen #(
        .RESET_ADDR (32'hbfc0_0000),
        .EXC_ADDR   (32'hbfc0_0380),
        .FETCH_W    (1),
        .MAX_OUTST  (2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .eret      (eret),
        .epc       (epc),
        .exc_oc    (exc_oc),
        .br_take   (br_take),
        .br_target (br_target),
        .mem       (if1),
        .pc        (pc1),
        .outst     (outst1)
    );

    fetch_pc_gen #(
        .RESET_ADDR (32'hbfc0_0000),
        .EXC_ADDR   (32'hbfc0_0380),
        .FETCH_W    (4),
        .MAX_OUTST  (2)
    ) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .eret      (eret),
        .epc       (epc),
        .exc_oc    (exc_oc),
        .br_take   (br_take),
        .br_target (br_target),
        .mem       (if4),
        .pc        (pc4),
        .outst     (outst4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // inputs change right after the falling edge; checks land 1 time unit later
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; stall = 1'b0; eret = 1'b0; epc = '0; exc_oc = 1'b0;
        br_take = 1'b0; br_target = '0; ready = 1'b0; resp = 1'b0;
        repeat (3) cyc();
        #1;
        check("rst_valid",   32'(if1.req_valid),    32'd0);
        check("rst_outst",   32'(outst1),           32'd0);
        check("rst_pc",      pc1,                   32'hbfc0_0000);
        check("rst_discard", 32'(if1.resp_discard), 32'd0);

        // sequential fetch up to the outstanding limit
        cyc(); reset = 1'b0; ready = 1'b1; #1;
        check("t1_valid0", 32'(if1.req_valid), 32'd1);
        check("t1_addr0",  if1.req_addr,       32'hbfc0_0000);
        check("t1_outst0", 32'(outst1),        32'd0);
        cyc(); #1;
        check("t1_addr1",  if1.req_addr,       32'hbfc0_0004);
        check("t1_outst1", 32'(outst1),        32'd1);
        cyc(); resp = 1'b1; #1;
        check("t1_full_valid", 32'(if1.req_valid),    32'd0);
        check("t1_full_outst", 32'(outst1),           32'd2);
        check("t1_pc2",        pc1,                   32'hbfc0_0008);
        check("t1_discard",    32'(if1.resp_discard), 32'd0);
        cyc(); resp = 1'b0; #1;
        check("t1_valid2", 32'(if1.req_valid), 32'd1);
        check("t1_addr2",  if1.req_addr,       32'hbfc0_0008);
        cyc(); resp = 1'b1; ready = 1'b0; stall = 1'b1; #1;
        check("t1_outst_max", 32'(outst1), 32'd2);
        cyc(); #1;
        cyc(); resp = 1'b0; stall = 1'b0; ready = 1'b1; #1;
        check("t1_drained", 32'(outst1),    32'd0);
        check("t1_addr3",   if1.req_addr,   32'hbfc0_000c);

        // held request with a branch arriving while held
        cyc(); resp = 1'b1; ready = 1'b0; #1;
        check("t3_valid_pre", 32'(if1.req_valid), 32'd1);
        check("t3_addr_pre",  if1.req_addr,       32'hbfc0_0010);
        cyc(); resp = 1'b0; br_take = 1'b1; br_target = 32'h8000_0100; #1;
        check("t3_hold_valid", 32'(if1.req_valid), 32'd1);
        check("t3_hold_addr",  if1.req_addr,       32'hbfc0_0010);
        cyc(); br_take = 1'b0; #1;
        check("t3_hold_addr2", if1.req_addr, 32'hbfc0_0010);
        check("t3_hold_pc",    pc1,          32'hbfc0_0010);
        cyc(); ready = 1'b1; #1;
        check("t3_fire_addr", if1.req_addr, 32'hbfc0_0010);
        cyc(); resp = 1'b1; #1;
        check("t3_stale_disc", 32'(if1.resp_discard), 32'd1);
        check("t3_new_valid",  32'(if1.req_valid),    32'd1);
        check("t3_new_addr",   if1.req_addr,          32'h8000_0100);
        cyc(); ready = 1'b0; stall = 1'b1; #1;
        check("t3_good_disc",  32'(if1.resp_discard), 32'd0);
        check("t3_outst",      32'(outst1),           32'd1);

        // 4-wide group: mask from the target's slot offset
        cyc(); resp = 1'b0; stall = 1'b0; br_take = 1'b1; br_target = 32'h8000_0008; #1;
        check("t2_redir_valid", 32'(if4.req_valid), 32'd0);
        cyc(); br_take = 1'b0; ready = 1'b1; #1;
        check("t2_valid", 32'(if4.req_valid), 32'd1);
        check("t2_addr0", if4.req_addr,       32'h8000_0000);
        check("t2_mask0", 32'(if4.req_mask),  32'h0000_000c);
        check("t2_w1_addr", if1.req_addr,     32'h8000_0008);
        check("t2_w1_mask", 32'(if1.req_mask), 32'd1);
        cyc(); #1;
        check("t2_addr1", if4.req_addr,      32'h8000_0010);
        check("t2_mask1", 32'(if4.req_mask), 32'h0000_000f);
        cyc(); ready = 1'b0; resp = 1'b1; stall = 1'b1; #1;
        check("t2_outst", 32'(outst4), 32'd2);
        cyc(); #1;

        // redirect priority
        cyc(); resp = 1'b0; stall = 1'b0; eret = 1'b1; epc = 32'h8000_0200;
        exc_oc = 1'b1; br_take = 1'b1; br_target = 32'h8000_0100; #1;
        check("t4_redir_valid", 32'(if1.req_valid), 32'd0);
        cyc(); eret = 1'b0; exc_oc = 1'b0; br_take = 1'b0; stall = 1'b1; #1;
        check("t4_eret_pc", pc1, 32'h8000_0200);
        cyc(); exc_oc = 1'b1; br_take = 1'b1; #1;
        cyc(); exc_oc = 1'b0; br_take = 1'b0; #1;
        check("t4_exc_pc", pc1, 32'hbfc0_0380);

        // two in flight, then branch: both responses discarded
        cyc(); stall = 1'b0; ready = 1'b1; #1;
        check("t5_addr0", if1.req_addr, 32'hbfc0_0380);
        cyc(); #1;
        check("t5_addr1", if1.req_addr, 32'hbfc0_0384);
        cyc(); ready = 1'b0; br_take = 1'b1; br_target = 32'h8000_0300; #1;
        check("t5_outst", 32'(outst1), 32'd2);
        cyc(); br_take = 1'b0; resp = 1'b1; #1;
        check("t5_disc0",  32'(if1.resp_discard), 32'd1);
        check("t5_valid0", 32'(if1.req_valid),    32'd0);
        cyc(); ready = 1'b1; #1;
        check("t5_disc1",  32'(if1.resp_discard), 32'd1);
        check("t5_addr",   if1.req_addr,          32'h8000_0300);
        cyc(); ready = 1'b0; stall = 1'b1; #1;
        check("t5_disc2",  32'(if1.resp_discard), 32'd0);

        // reset while holding with a pending redirect and a request in flight
        cyc(); resp = 1'b0; stall = 1'b0; ready = 1'b1; #1;
        check("t6_addr0", if1.req_addr, 32'h8000_0304);
        cyc(); ready = 1'b0; #1;
        check("t6_addr1", if1.req_addr, 32'h8000_0308);
        cyc(); br_take = 1'b1; br_target = 32'h8000_0400; #1;
        check("t6_hold_addr", if1.req_addr, 32'h8000_0308);
        check("t6_outst_pre", 32'(outst1),  32'd1);
        cyc(); br_take = 1'b0; reset = 1'b1; #1;
        check("t6_rst_valid", 32'(if1.req_valid), 32'd0);
        check("t6_rst_outst", 32'(outst1),        32'd0);
        check("t6_rst_pc",    pc1,                32'hbfc0_0000);
        cyc(); reset = 1'b0; ready = 1'b1; #1;
        check("t6_valid", 32'(if1.req_valid), 32'd1);
        check("t6_addr",  if1.req_addr,       32'hbfc0_0000);
        cyc(); ready = 1'b0; stall = 1'b1; resp = 1'b1; #1;
        check("t6_disc", 32'(if1.resp_discard), 32'd0);
        cyc(); resp = 1'b0; #1;
        check("t6_outst_end", 32'(outst1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
